// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle RISC-V control unit: opcodes, ALU codes,
// FSM state encoding and datapath select values.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } alu_op_e;

  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;
  localparam logic [2:0] ALUC_XOR = 3'b100;
  localparam logic [2:0] ALUC_SLT = 3'b101;
  localparam logic [2:0] ALUC_SLL = 3'b110;
  localparam logic [2:0] ALUC_SRL = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_ILLEGAL
  } state_e;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;

  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;

  localparam logic [1:0] IMM_I       = 2'b00;
  localparam logic [1:0] IMM_S       = 2'b01;
  localparam logic [1:0] IMM_B       = 2'b10;
  localparam logic [1:0] IMM_J       = 2'b11;

  // Immediate format implied by the opcode; anything without its own format uses I.
  function automatic logic [1:0] imm_for_op(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath/memory signal bundle. master = control unit,
// slave = datapath side.
interface multicycle_control_if;
  logic [6:0] op_i;
  logic [2:0] funct3_i;
  logic       funct7b5_i;
  logic       zero_i;
  logic       mem_ready_i;

  logic [2:0] alucontrol_o;
  logic [1:0] alusrca_o;
  logic [1:0] alusrcb_o;
  logic [1:0] resultsrc_o;
  logic [1:0] immsrc_o;
  logic       adrsrc_o;
  logic       pcwrite_o;
  logic       irwrite_o;
  logic       memwrite_o;
  logic       regwrite_o;
  logic       illegal_o;

  modport master (
    input  op_i, funct3_i, funct7b5_i, zero_i, mem_ready_i,
    output alucontrol_o, alusrca_o, alusrcb_o, resultsrc_o, immsrc_o,
           adrsrc_o, pcwrite_o, irwrite_o, memwrite_o, regwrite_o, illegal_o
  );

  modport slave (
    output op_i, funct3_i, funct7b5_i, zero_i, mem_ready_i,
    input  alucontrol_o, alusrca_o, alusrcb_o, resultsrc_o, immsrc_o,
           adrsrc_o, pcwrite_o, irwrite_o, memwrite_o, regwrite_o, illegal_o
  );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's ALU request plus funct fields to the
// 3-bit ALU operation code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_e    aluop_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       opb5_i,
  output logic [2:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = ALUC_ADD;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALUC_ADD;
      ALUOP_SUB: alucontrol_o = ALUC_SUB;
      default: begin
        case (funct3_i)
          // op bit 5 separates R-type from I-type, so addi never becomes sub
          3'b000:  alucontrol_o = (opb5_i && funct7b5_i) ? ALUC_SUB : ALUC_ADD;
          3'b001:  alucontrol_o = ALUC_SLL;
          3'b010:  alucontrol_o = ALUC_SLT;
          3'b011:  alucontrol_o = ALUC_SLT;
          3'b100:  alucontrol_o = ALUC_XOR;
          3'b101:  alucontrol_o = ALUC_SRL;
          3'b110:  alucontrol_o = ALUC_OR;
          default: alucontrol_o = ALUC_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects, write strobes and the ALU operation code.
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter bit RESET_ILLEGAL = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  multicycle_control_if.master   bus
);

  state_e     state_q, state_d;
  alu_op_e    aluop;
  logic [2:0] alucontrol;
  logic [1:0] srca, srcb, res, imm;
  logic       adr, irw, pcupdate, branch, memw, regw, illegal;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    aluop    = ALUOP_ADD;
    srca     = SRCA_PC;
    srcb     = SRCB_RS2;
    res      = RES_ALUOUT;
    imm      = IMM_I;
    adr      = 1'b0;
    irw      = 1'b0;
    pcupdate = 1'b0;
    branch   = 1'b0;
    memw     = 1'b0;
    regw     = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        srcb     = SRCB_FOUR;
        res      = RES_ALURES;
        irw      = bus.mem_ready_i;
        pcupdate = bus.mem_ready_i;
        if (bus.mem_ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        srca = SRCA_OLDPC;
        srcb = SRCB_IMM;
        imm  = imm_for_op(bus.op_i);
        case (bus.op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            illegal = 1'b1;
            state_d = RESET_ILLEGAL ? S_ILLEGAL : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        srca    = SRCA_RS1;
        srcb    = SRCB_IMM;
        imm     = (bus.op_i == OP_SW) ? IMM_S : IMM_I;
        state_d = (bus.op_i == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr = 1'b1;
        if (bus.mem_ready_i) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        res     = RES_MEMDATA;
        regw    = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        adr  = 1'b1;
        memw = 1'b1;
        if (bus.mem_ready_i) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        srca    = SRCA_RS1;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        srca    = SRCA_RS1;
        srcb    = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regw    = 1'b1;
        state_d = S_FETCH;
      end
      S_BEQ: begin
        srca    = SRCA_RS1;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        srca     = SRCA_OLDPC;
        srcb     = SRCB_FOUR;
        imm      = IMM_J;
        pcupdate = 1'b1;
        state_d  = S_ALUWB;
      end
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop_i      (aluop),
    .funct3_i     (bus.funct3_i),
    .funct7b5_i   (bus.funct7b5_i),
    .opb5_i       (bus.op_i[5]),
    .alucontrol_o (alucontrol)
  );

  // Strobes are gated by rst_i directly so an access in flight is killed within
  // the same cycle reset rises, not at the next edge.
  assign bus.alucontrol_o = alucontrol;
  assign bus.alusrca_o    = srca;
  assign bus.alusrcb_o    = srcb;
  assign bus.resultsrc_o  = res;
  assign bus.immsrc_o     = imm;
  assign bus.adrsrc_o     = adr;
  assign bus.irwrite_o    = irw & ~rst_i;
  assign bus.pcwrite_o    = (pcupdate | (branch & bus.zero_i)) & ~rst_i;
  assign bus.memwrite_o   = memw & ~rst_i;
  assign bus.regwrite_o   = regw & ~rst_i;
  assign bus.illegal_o    = illegal & ~rst_i;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: an instruction-step model checked
// every cycle, plus hand-computed literal checks on key cycles.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_if bus();

  multicycle_control #(.RESET_ILLEGAL(1'b0)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0] alu;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] res;
    logic [1:0] imm;
    logic       adr;
    logic       pcw;
    logic       irw;
    logic       mw;
    logic       rw;
    logic       ill;
  } out_t;

  localparam int C_LW = 1, C_SW = 2, C_R = 3, C_I = 4, C_BEQ = 5, C_JAL = 6, C_ILL = 7;

  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;
  int   m_step = 0;
  int   m_cls  = 0;
  out_t obs [0:15];

  function automatic int classify(input logic [6:0] op);
    case (op)
      7'b0000011: return C_LW;
      7'b0100011: return C_SW;
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b1100011: return C_BEQ;
      7'b1101111: return C_JAL;
      default:    return C_ILL;
    endcase
  endfunction

  // Total cycles of each instruction class with no memory waits.
  function automatic int len_of(input int c);
    case (c)
      C_LW:  return 5;
      C_SW:  return 4;
      C_R:   return 4;
      C_I:   return 4;
      C_BEQ: return 3;
      C_JAL: return 4;
      default: return 2;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [2:0] f3, input logic is_sub);
    logic [2:0] tbl [8];
    tbl = '{3'b000, 3'b110, 3'b101, 3'b101, 3'b100, 3'b111, 3'b011, 3'b010};
    if (f3 == 3'b000 && is_sub) return 3'b001;
    return tbl[f3];
  endfunction

  function automatic out_t model_out(input int cls, input int step, input logic [2:0] f3,
                                     input logic f7, input logic z, input logic mr,
                                     input logic r);
    out_t e;
    e = '0;
    if (r || step == 0) begin
      e.b   = 2'b10;
      e.res = 2'b10;
      e.irw = mr & ~r;
      e.pcw = mr & ~r;
      return e;
    end
    if (step == 1) begin
      e.a   = 2'b01;
      e.b   = 2'b01;
      e.imm = (cls == C_SW) ? 2'b01 : (cls == C_BEQ) ? 2'b10 : (cls == C_JAL) ? 2'b11 : 2'b00;
      e.ill = (cls == C_ILL);
      return e;
    end
    if ((cls == C_LW || cls == C_SW) && step == 2) begin
      e.a = 2'b10; e.b = 2'b01; e.imm = (cls == C_SW) ? 2'b01 : 2'b00;
    end
    if (cls == C_LW && step == 3) e.adr = 1'b1;
    if (cls == C_LW && step == 4) begin e.res = 2'b01; e.rw = 1'b1; end
    if (cls == C_SW && step == 3) begin e.adr = 1'b1; e.mw = 1'b1; end
    if (cls == C_R && step == 2) begin e.a = 2'b10; e.alu = funct_alu(f3, f7); end
    if (cls == C_I && step == 2) begin e.a = 2'b10; e.b = 2'b01; e.alu = funct_alu(f3, 1'b0); end
    if ((cls == C_R || cls == C_I || cls == C_JAL) && step == 3) e.rw = 1'b1;
    if (cls == C_BEQ && step == 2) begin e.a = 2'b10; e.alu = 3'b001; e.pcw = z; end
    if (cls == C_JAL && step == 2) begin e.a = 2'b01; e.b = 2'b10; e.imm = 2'b11; e.pcw = 1'b1; end
    return e;
  endfunction

  function automatic out_t dut_now();
    out_t g;
    g.alu = bus.alucontrol_o; g.a = bus.alusrca_o; g.b = bus.alusrcb_o;
    g.res = bus.resultsrc_o; g.imm = bus.immsrc_o; g.adr = bus.adrsrc_o;
    g.pcw = bus.pcwrite_o; g.irw = bus.irwrite_o; g.mw = bus.memwrite_o;
    g.rw = bus.regwrite_o; g.ill = bus.illegal_o;
    return g;
  endfunction

  always @(negedge clk) begin : cmp
    out_t e, g;
    bit   waiting;
    if (chk_en) begin
      if (rst) m_step = 0;
      if (m_step == 1) m_cls = classify(bus.op_i);
      e = model_out(m_cls, m_step, bus.funct3_i, bus.funct7b5_i, bus.zero_i,
                    bus.mem_ready_i, rst);
      g = dut_now();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL outputs t=%0t step=%0d got=%b exp=%b", $time, m_step, g, e);
      end
      waiting = (m_step == 0) || (m_step == 3 && (m_cls == C_LW || m_cls == C_SW));
      if (rst)                                    m_step = 0;
      else if (waiting && !bus.mem_ready_i)       m_step = m_step;
      else if (m_step != 0 && m_step + 1 >= len_of(m_cls)) m_step = 0;
      else                                        m_step = m_step + 1;
    end
  end

  task automatic lit(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Runs n cycles of one instruction; fw fetch waits, mw waits in the memory state.
  task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input logic z, input int fw, input int mw, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.op_i       = op;
      bus.funct3_i   = f3;
      bus.funct7b5_i = f7;
      bus.zero_i     = (i == fw + 2) ? z : 1'($urandom_range(1, 0));
      if (i < fw)                            bus.mem_ready_i = 1'b0;
      else if (i == fw)                      bus.mem_ready_i = 1'b1;
      else if (i >= fw + 3 && i < fw + 3 + mw) bus.mem_ready_i = 1'b0;
      else if (i == fw + 3 + mw)             bus.mem_ready_i = 1'b1;
      else                                   bus.mem_ready_i = 1'($urandom_range(1, 0));
      @(negedge clk);
      obs[i] = dut_now();
    end
  endtask

  function automatic int rw_count(input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) c += int'(obs[i].rw);
    return c;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.op_i = '0; bus.funct3_i = '0; bus.funct7b5_i = 1'b0;
    bus.zero_i = 1'b0; bus.mem_ready_i = 1'b0;
    #1 rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    lit("rst_alusrcb", 8'(bus.alusrcb_o), 8'h2);
    #1 bus.mem_ready_i = 1'b1;
    @(negedge clk);
    lit("rst_strobes", 8'({bus.irwrite_o, bus.pcwrite_o, bus.memwrite_o,
                           bus.regwrite_o, bus.illegal_o}), 8'h0);
    bus.mem_ready_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    do_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 2, 0, 6);
    lit("fetch_hold_irwrite", 8'(obs[1].irw), 8'h0);
    lit("fetch_irwrite", 8'(obs[2].irw), 8'h1);
    lit("fetch_pcwrite", 8'(obs[2].pcw), 8'h1);
    lit("fetch_alusrcb", 8'(obs[2].b), 8'h2);
    lit("r_sub_alu", 8'(obs[4].alu), 8'h1);
    lit("r_sub_regwrite", 8'(obs[5].rw), 8'h1);

    do_instr(7'b0110011, 3'b101, 1'b1, 1'b0, 0, 0, 4);
    lit("r_srl_alu", 8'(obs[2].alu), 8'h7);

    do_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, 4);
    lit("i_addi_alu", 8'(obs[2].alu), 8'h0);
    do_instr(7'b0010011, 3'b110, 1'b0, 1'b0, 0, 0, 4);

    do_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3, 8);
    lit("lw_adrsrc_wait", 8'(obs[4].adr), 8'h1);
    lit("lw_memwb_result", 8'(obs[7].res), 8'h1);
    lit("lw_memwb_regwrite", 8'(obs[7].rw), 8'h1);
    lit("lw_regwrite_count", 8'(rw_count(8)), 8'h1);

    do_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 1, 2, 7);
    lit("sw_memadr_imm", 8'(obs[3].imm), 8'h1);
    lit("sw_memwrite_wait", 8'(obs[5].mw), 8'h1);
    lit("sw_memwrite_done", 8'(obs[6].mw), 8'h1);
    lit("sw_no_regwrite", 8'(rw_count(7)), 8'h0);

    do_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, 3);
    lit("beq_taken_pcwrite", 8'(obs[2].pcw), 8'h1);
    lit("beq_alu", 8'(obs[2].alu), 8'h1);
    do_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, 3);
    lit("beq_nottaken_pcwrite", 8'(obs[2].pcw), 8'h0);

    do_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, 4);
    lit("jal_immsrc", 8'(obs[2].imm), 8'h3);
    lit("jal_pcwrite", 8'(obs[2].pcw), 8'h1);

    do_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, 2);
    lit("illegal_pulse", 8'(obs[1].ill), 8'h1);
    lit("illegal_quiet_fetch", 8'(obs[0].ill), 8'h0);
    do_instr(7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0, 4);
    lit("after_illegal_fetch", 8'(obs[0].irw), 8'h1);

    do_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 5, 4);
    lit("sw_memwrite_pre_rst", 8'(obs[3].mw), 8'h1);
    #2 rst = 1'b1;
    #1;
    lit("rst_memwrite_drop", 8'(bus.memwrite_o), 8'h0);
    lit("rst_adrsrc", 8'(bus.adrsrc_o), 8'h0);
    bus.mem_ready_i = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.mem_ready_i = 1'b0;

    do_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0, 5);
    lit("lw_latency_regwrite", 8'(obs[4].rw), 8'h1);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
